issue_scheduler: RTL
====================

# issue_scheduler

Single-FU issue queue and scheduler for the out-of-order core. Sits between rename/dispatch and one functional unit. Holds renamed instructions until both physical sources are ready, tracks readiness through writeback wakeup broadcasts, and issues the oldest ready entry by dynamic ID to the FU through a valid/ready handshake. Register read happens downstream; this block issues physical register IDs, not values.

## Interface
- NENTRIES, 8: queue depth (power of two, 2..16).
- N_WB, 2: number of writeback wakeup ports.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  squash all entries this cycle.
- disp_valid_i  in  1  dispatch request.
- disp_ready_o  out  1  queue can accept.
- disp_data_i  in  iq_entry_t  pc, id, prd, prs1, prs1_renammed, prs2, prs2_renammed, imm, fu, op.
- wb_valid_i  in  N_WB  wakeup valid per port.
- wb_prd_i  in  N_WB x PREG_ID_BITS  physical register now written.
- iss_valid_o  out  1  an entry is selected for issue.
- iss_ready_i  in  1  FU accepts.
- iss_data_o  out  iq_issue_t  pc, id, prd, prs1, prs2, imm, fu, op of selected entry.
- count_o  out  $clog2(NENTRIES)+1  occupied entries.

## Operation
- Entry state: valid, rdy1, rdy2, payload. Eligible = valid & rdy1 & rdy2.
- Dispatch fires when disp_valid_i & disp_ready_o; written into the lowest-index free entry.
- Source ready at dispatch: rdyX = !prsX_renammed, or prsX matches any wb_valid_i/wb_prd_i in the same cycle. The dispatch-cycle match is mandatory in all configurations (no lost wakeups).
- Wakeup: for every valid entry, rdyX set when any wb port is valid with wb_prd_i == prsX. Ready bits never clear while the entry is valid.
- Select: among eligible entries, the oldest by ID wins. older(a,b) = MSB of (a - b) modulo 2^ID_BITS, so ordering is wrap-safe provided the in-flight ID span is < 2^(ID_BITS-1). On equal IDs (illegal), the lower index wins.
- Issue fires when iss_valid_o & iss_ready_i; the selected entry is invalidated on that edge.
- iss_data_o is combinational from the current entry state. It may change between cycles while iss_ready_i is low, for example when an older entry becomes eligible. The FU samples only on fire.
- Flush: on the next edge all entries are invalid and count is 0. The same-cycle dispatch and issue are both discarded.

## Timing
- Reset values: all entries invalid; count_o = 0; iss_valid_o = 0; disp_ready_o = 0 during reset and 1 in the first cycle after it.
- disp_ready_o = (count < NENTRIES) & !flush_i. It depends on the registered count only, so a full queue refuses dispatch even in a cycle that also issues.
- iss_valid_o is forced to 0 while flush_i is high.
- Dispatch to earliest issue: an entry dispatched in cycle N with ready sources is eligible in cycle N+1.
- Wakeup in cycle N:
  - Without the bypass macro, the entry is eligible in N+1.
  - With the bypass macro, the entry is eligible in N.
- Simultaneous dispatch and issue: count unchanged. A freed slot is reusable from the next cycle.
- The count update is registered; there is no under- or overflow: issue requires a valid entry, and dispatch requires count < NENTRIES.

## Configuration
- IQ_WAKEUP_BYPASS_EN defined: the same-cycle wakeup match is ORed into the eligibility term, so a woken entry can issue in the wakeup cycle. This adds a combinational path wb_prd_i -> iss_valid_o/iss_data_o.
- Not defined: eligibility uses registered ready bits only; woken entries issue one cycle later. There is no combinational path from wb inputs to issue outputs.

## Structure
- Package C gains typedef iq_entry_t (packed: pc, id, prd, prs1, prs1_renammed, prs2, prs2_renammed, imm, fu, op), typedef iq_issue_t, and parameter IQ_NENTRIES = 8.
- Sub-module iq_select: a combinational oldest-eligible picker. Input is the per-entry eligible vector plus IDs; outputs are a one-hot grant and an any flag. It is implemented as a pairwise age-compare reduction.

## Test plan
- Reset, then dispatch id=5 with prs1_renammed=0 and prs2_renammed=0, iss_ready_i=1 -> iss_valid_o=1 the next cycle with id=5; count returns to 0.
- Dispatch id=10 (prs1=3, renamed), then id=11 (ready), then assert wb_prd_i[0]=3 -> id=11 issues first; id=10 issues one cycle after the wakeup, or in the same cycle with the macro defined.
- Dispatch prs1=7 in the same cycle as wb_prd_i[1]=7 -> the entry issues the next cycle and is never stuck.
- Wrap: dispatch id=0xFFFFE then id=0x00001, both ready -> 0xFFFFE issues first.
- Fill 8 entries with iss_ready_i=0 -> disp_ready_o=0 and the 9th dispatch is held. Raise iss_ready_i and keep disp_valid_i high -> exactly one issue per cycle, and the 9th dispatch is accepted the cycle after the first issue.
- With 4 entries valid, assert flush_i together with disp_valid_i and iss_ready_i -> there is no issue fire that cycle; the next cycle count_o=0 and iss_valid_o=0.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared types for the single-FU issue queue: entry/issue payloads, field
// widths and the wrap-safe age compare used by the select tree.
package issue_scheduler_pkg;

    parameter int IQ_NENTRIES = 8;

    localparam int PC_BITS      = 32;
    localparam int ID_BITS      = 20;
    localparam int PREG_ID_BITS = 7;
    localparam int IMM_BITS     = 32;
    localparam int FU_BITS      = 3;
    localparam int OP_BITS      = 6;

    typedef logic [ID_BITS-1:0]      iq_id_t;
    typedef logic [PREG_ID_BITS-1:0] preg_id_t;

    typedef struct packed {
        logic [PC_BITS-1:0]  pc;
        iq_id_t              id;
        preg_id_t            prd;
        preg_id_t            prs1;
        logic                prs1_renammed;
        preg_id_t            prs2;
        logic                prs2_renammed;
        logic [IMM_BITS-1:0] imm;
        logic [FU_BITS-1:0]  fu;
        logic [OP_BITS-1:0]  op;
    } iq_entry_t;

    typedef struct packed {
        logic [PC_BITS-1:0]  pc;
        iq_id_t              id;
        preg_id_t            prd;
        preg_id_t            prs1;
        preg_id_t            prs2;
        logic [IMM_BITS-1:0] imm;
        logic [FU_BITS-1:0]  fu;
        logic [OP_BITS-1:0]  op;
    } iq_issue_t;

    // a is older than b when (a - b) is negative modulo 2^ID_BITS
    function automatic logic iq_older(iq_id_t a, iq_id_t b);
        iq_id_t d;
        d = a - b;
        return d[ID_BITS-1];
    endfunction

    function automatic iq_issue_t iq_to_issue(iq_entry_t e);
        iq_issue_t r;
        r.pc   = e.pc;
        r.id   = e.id;
        r.prd  = e.prd;
        r.prs1 = e.prs1;
        r.prs2 = e.prs2;
        r.imm  = e.imm;
        r.fu   = e.fu;
        r.op   = e.op;
        return r;
    endfunction

endpackage

// File: rtl/issue_scheduler_select.sv
// Oldest-eligible picker: binary tournament over entries, each node keeping
// the older of its two children. Left child carries lower indices, so on
// equal IDs the lower index wins.
module iq_select
    import issue_scheduler_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]   elig,
    input  iq_id_t [N-1:0] ids,
    output logic [N-1:0]   grant,
    output logic           found
);

    localparam int LW = $clog2(N);

    // heap-ordered tree: node i has children 2i and 2i+1, leaves at N..2N-1
    logic [2*N-1:1] nv;
    iq_id_t         nid  [1:2*N-1];
    logic [LW-1:0]  nidx [1:2*N-1];

    // reduce leaves to the root, children always evaluated before parents
    always_comb begin
        nv = '0;
        for (int i = 1; i < 2*N; i++) begin
            nid[i]  = '0;
            nidx[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            nv[N+i]   = elig[i];
            nid[N+i]  = ids[i];
            nidx[N+i] = LW'(i);
        end
        for (int i = N-1; i >= 1; i--) begin
            if (nv[2*i] && (!nv[2*i+1] || !iq_older(nid[2*i+1], nid[2*i]))) begin
                nid[i]  = nid[2*i];
                nidx[i] = nidx[2*i];
            end else begin
                nid[i]  = nid[2*i+1];
                nidx[i] = nidx[2*i+1];
            end
            nv[i] = nv[2*i] | nv[2*i+1];
        end
        found = nv[1];
        grant = '0;
        if (nv[1]) grant[nidx[1]] = 1'b1;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Single-FU issue queue: holds renamed ops until both sources are ready,
// tracks writeback wakeups, issues the oldest ready op by dynamic ID.
// IQ_WAKEUP_BYPASS_EN: when defined, same-cycle wakeups feed eligibility so
// a woken entry may issue in the wakeup cycle (wb -> issue comb path).
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int NENTRIES = IQ_NENTRIES,
    parameter int N_WB     = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic                               disp_valid_i,
    output logic                               disp_ready_o,
    input  iq_entry_t                          disp_data_i,
    input  logic [N_WB-1:0]                    wb_valid_i,
    input  logic [N_WB-1:0][PREG_ID_BITS-1:0]  wb_prd_i,
    output logic                               iss_valid_o,
    input  logic                               iss_ready_i,
    output iq_issue_t                          iss_data_o,
    output logic [$clog2(NENTRIES):0]          count_o
);

    localparam int CW = $clog2(NENTRIES) + 1;

    logic [NENTRIES-1:0] ent_vld, ent_rdy1, ent_rdy2;
    iq_entry_t           ent [NENTRIES];
    logic [CW-1:0]       count;

    logic [NENTRIES-1:0] wake1, wake2, elig, free_sel, grant;
    iq_id_t [NENTRIES-1:0] ids;
    logic                dwake1, dwake2, free_hit, sel_any;
    logic                disp_fire, iss_fire;

    // wakeup matches for resident entries and for the op being dispatched
    always_comb begin
        wake1  = '0;
        wake2  = '0;
        dwake1 = 1'b0;
        dwake2 = 1'b0;
        for (int w = 0; w < N_WB; w++) begin
            if (wb_valid_i[w]) begin
                for (int i = 0; i < NENTRIES; i++) begin
                    if (wb_prd_i[w] == ent[i].prs1) wake1[i] = 1'b1;
                    if (wb_prd_i[w] == ent[i].prs2) wake2[i] = 1'b1;
                end
                if (wb_prd_i[w] == disp_data_i.prs1) dwake1 = 1'b1;
                if (wb_prd_i[w] == disp_data_i.prs2) dwake2 = 1'b1;
            end
        end
    end

    // eligibility; the bypass variant lets this cycle's wakeups count
    always_comb begin
`ifdef IQ_WAKEUP_BYPASS_EN
        elig = ent_vld & (ent_rdy1 | wake1) & (ent_rdy2 | wake2);
`else
        elig = ent_vld & ent_rdy1 & ent_rdy2;
`endif
        for (int i = 0; i < NENTRIES; i++) ids[i] = ent[i].id;
    end

    // lowest-index free slot receives the dispatch
    always_comb begin
        free_sel = '0;
        free_hit = 1'b0;
        for (int i = 0; i < NENTRIES; i++) begin
            if (!ent_vld[i] && !free_hit) begin
                free_sel[i] = 1'b1;
                free_hit    = 1'b1;
            end
        end
    end

    iq_select #(.N(NENTRIES)) u_select (
        .elig  (elig),
        .ids   (ids),
        .grant (grant),
        .found (sel_any)
    );

    // registered count only, so a full queue refuses dispatch even while issuing
    assign disp_ready_o = !rst_i && !flush_i && (count < CW'(NENTRIES));
    assign iss_valid_o  = sel_any && !flush_i && !rst_i;
    assign disp_fire    = disp_valid_i && disp_ready_o;
    assign iss_fire     = iss_valid_o && iss_ready_i;
    assign count_o      = count;

    // payload of the granted entry
    always_comb begin
        iss_data_o = '0;
        for (int i = 0; i < NENTRIES; i++)
            if (grant[i]) iss_data_o = iq_to_issue(ent[i]);
    end

    // entry state: reset/flush clear, wakeups accumulate, issue frees, dispatch fills
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ent_vld <= '0;
            count   <= '0;
        end else begin
            count <= count + CW'(disp_fire) - CW'(iss_fire);
            for (int i = 0; i < NENTRIES; i++) begin
                ent_rdy1[i] <= ent_rdy1[i] | wake1[i];
                ent_rdy2[i] <= ent_rdy2[i] | wake2[i];
                if (iss_fire && grant[i]) ent_vld[i] <= 1'b0;
                if (disp_fire && free_sel[i]) begin
                    ent_vld[i]  <= 1'b1;
                    ent[i]      <= disp_data_i;
                    ent_rdy1[i] <= !disp_data_i.prs1_renammed || dwake1;
                    ent_rdy2[i] <= !disp_data_i.prs2_renammed || dwake2;
                end
            end
        end
    end

endmodule
